// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the Olivia instruction-memory boot loader.
// Holds the FSM state encoding, error codes and header/depth defaults.
package imem_boot_loader_pkg;

    localparam int IM_WORDS_DEFAULT = 16;
    localparam int HDR_W            = 16;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    typedef enum logic [2:0] {
        ST_HDR_HI  = 3'd0,
        ST_HDR_LO  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } loaderState_t;

    // The loader takes bytes in every state except the two terminal ones.
    function automatic logic stateAcceptsBytes(input loaderState_t s);
        return (s != ST_DONE) && (s != ST_ERR);
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; the first byte of a
// word ends up in [31:24]. Partial words are held while no bytes arrive.
module imem_boot_loader_byte_packer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        clear_i,
    input  logic        byteValid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        wordValid_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  byteIdx_q, byteIdx_d;

    always_comb begin
        shift_d   = shift_q;
        byteIdx_d = byteIdx_q;
        if (clear_i) begin
            shift_d   = '0;
            byteIdx_d = '0;
        end else if (byteValid_i) begin
            shift_d   = {shift_q[15:0], byte_i};
            byteIdx_d = byteIdx_q + 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            shift_q   <= '0;
            byteIdx_q <= '0;
        end else begin
            shift_q   <= shift_d;
            byteIdx_q <= byteIdx_d;
        end
    end

    // The completed word is offered in the same cycle as its 4th byte.
    assign word_o      = {shift_q, byte_i};
    assign wordValid_o = byteValid_i && !clear_i && (byteIdx_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction
// memory and holds the Olivia core in reset until the image is verified.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int IM_WORDS = IM_WORDS_DEFAULT,
    parameter int AW       = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    input  logic          restart,
    output logic          im_we,
    output logic [AW-1:0] im_waddr,
    output logic [31:0]   im_wdata,
    output logic          core_rst,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW:0]   words_loaded
);

    loaderState_t state_q, state_d;
    logic [7:0]   lenHi_q, lenHi_d;
    logic [AW:0]  lenWords_q, lenWords_d;
    logic [AW:0]  wordsLoaded_q, wordsLoaded_d;
    logic [7:0]   csum_q, csum_d;
    logic         imWe_q, imWe_d;
    logic [AW-1:0] imWaddr_q, imWaddr_d;
    logic [31:0]  imWdata_q, imWdata_d;
    logic         coreRst_q, coreRst_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [1:0]   errCode_q, errCode_d;

    logic             accept;
    logic             packValid;
    logic             packClear;
    logic [31:0]      packWord;
    logic             packWordValid;
    logic [HDR_W-1:0] hdrLen;
    logic [AW:0]      wordsNext;

    assign s_ready   = stateAcceptsBytes(state_q);
    assign accept    = s_valid && s_ready;
    assign packValid = accept && (state_q == ST_PAYLOAD);
    assign packClear = restart && ((state_q == ST_DONE) || (state_q == ST_ERR));
    assign hdrLen    = {lenHi_q, s_data};
    assign wordsNext = wordsLoaded_q + (AW+1)'(1);

    imem_boot_loader_byte_packer uPacker (
        .CLK         (CLK),
        .RST         (RST),
        .clear_i     (packClear),
        .byteValid_i (packValid),
        .byte_i      (s_data),
        .word_o      (packWord),
        .wordValid_o (packWordValid)
    );

    always_comb begin
        state_d       = state_q;
        lenHi_d       = lenHi_q;
        lenWords_d    = lenWords_q;
        wordsLoaded_d = wordsLoaded_q;
        csum_d        = csum_q;
        imWe_d        = 1'b0;
        imWaddr_d     = imWaddr_q;
        imWdata_d     = imWdata_q;
        coreRst_d     = coreRst_q;
        done_d        = done_q;
        err_d         = err_q;
        errCode_d     = errCode_q;

        case (state_q)
            ST_HDR_HI: begin
                if (accept) begin
                    lenHi_d = s_data;
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                // Oversized images are rejected here so no word is ever written.
                if (accept) begin
                    if (hdrLen > HDR_W'(IM_WORDS)) begin
                        state_d   = ST_ERR;
                        err_d     = 1'b1;
                        errCode_d = ERR_LEN;
                    end else if (hdrLen == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        lenWords_d = hdrLen[AW:0];
                        state_d    = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    csum_d = csum_q ^ s_data;
                    if (packWordValid) begin
                        imWe_d        = 1'b1;
                        imWaddr_d     = wordsLoaded_q[AW-1:0];
                        imWdata_d     = packWord;
                        wordsLoaded_d = wordsNext;
                        if (wordsNext == lenWords_q) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (s_data == csum_q) begin
                        state_d   = ST_DONE;
                        coreRst_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d   = ST_ERR;
                        err_d     = 1'b1;
                        errCode_d = ERR_CSUM;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (restart) begin
                    state_d       = ST_HDR_HI;
                    coreRst_d     = 1'b1;
                    done_d        = 1'b0;
                    err_d         = 1'b0;
                    errCode_d     = ERR_NONE;
                    wordsLoaded_d = '0;
                    csum_d        = '0;
                end
            end
            default: begin
                state_d = ST_HDR_HI;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= ST_HDR_HI;
            lenHi_q       <= '0;
            lenWords_q    <= '0;
            wordsLoaded_q <= '0;
            csum_q        <= '0;
            imWe_q        <= 1'b0;
            imWaddr_q     <= '0;
            imWdata_q     <= '0;
            coreRst_q     <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            errCode_q     <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            lenHi_q       <= lenHi_d;
            lenWords_q    <= lenWords_d;
            wordsLoaded_q <= wordsLoaded_d;
            csum_q        <= csum_d;
            imWe_q        <= imWe_d;
            imWaddr_q     <= imWaddr_d;
            imWdata_q     <= imWdata_d;
            coreRst_q     <= coreRst_d;
            done_q        <= done_d;
            err_q         <= err_d;
            errCode_q     <= errCode_d;
        end
    end

    assign im_we        = imWe_q;
    assign im_waddr     = imWaddr_q;
    assign im_wdata     = imWdata_q;
    assign core_rst     = coreRst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = errCode_q;
    assign words_loaded = wordsLoaded_q;

endmodule
